// File: rtl/vga_arb_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | vga_arb_pkg : shared widths, requester ids and arbiter states    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package vga_arb_pkg;
    localparam int X_W = 8;
    localparam int Y_W = 7;
    localparam int C_W = 3;

    localparam int REQ_PLAYER = 0;
    localparam int REQ_WALL   = 1;
    localparam int REQ_CLEAR  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        GAP   = 2'd2
    } arb_state_t;
endpackage
`default_nettype wire

// File: rtl/vga_arbiter_rr_select.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | rr_select : combinational round-robin picker, search from ptr up |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module rr_select #(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_onehot,
    output logic [IW-1:0] o_index
);
    logic [IW-1:0] w_k;

    // Walk offsets from farthest to nearest so the closest requester to ptr wins.
    always_comb begin
        o_onehot = '0;
        o_index  = '0;
        w_k      = '0;
        for (int i = N - 1; i >= 0; i--) begin
            w_k = IW'((int'(i_ptr) + i) % N);
            if (i_req[w_k]) begin
                o_onehot      = '0;
                o_onehot[w_k] = 1'b1;
                o_index       = w_k;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/vga_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | vga_arbiter : round-robin burst arbiter for the VGA plot port    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module vga_arbiter
    import vga_arb_pkg::*;
#(
    parameter int N         = 3,
    parameter int MAX_BURST = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             busy,
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     valid,
    input  logic [N-1:0]     last,
    input  logic [X_W*N-1:0] x_in,
    input  logic [Y_W*N-1:0] y_in,
    input  logic [C_W*N-1:0] color_in,
    output logic [N-1:0]     ack,
    output logic [N-1:0]     grant,
    output logic             plot,
    output logic [X_W-1:0]   x_out,
    output logic [Y_W-1:0]   y_out,
    output logic [C_W-1:0]   color_out,
    output logic             active
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(MAX_BURST + 1);

    arb_state_t     r_state;
    logic [N-1:0]   r_grant;
    logic [IW-1:0]  r_owner;
    logic [IW-1:0]  r_ptr;
    logic [CW-1:0]  r_cnt;
    logic           r_plot;
    logic [X_W-1:0] r_x;
    logic [Y_W-1:0] r_y;
    logic [C_W-1:0] r_color;

    logic [N-1:0]   w_sel_onehot;
    logic [IW-1:0]  w_sel_index;
    logic           w_accept;
    logic           w_last;
    logic           w_own_req;
    logic [CW-1:0]  w_cnt_nxt;
    logic [IW-1:0]  w_ptr_nxt;
    logic [X_W-1:0] w_x;
    logic [Y_W-1:0] w_y;
    logic [C_W-1:0] w_color;

    rr_select #(
        .N  (N),
        .IW (IW)
    ) u_rr_select (
        .i_req    (req),
        .i_ptr    (r_ptr),
        .o_onehot (w_sel_onehot),
        .o_index  (w_sel_index)
    );

    // The one-hot grant doubles as the owner mask, so no decoder is needed on the accept path.
    assign w_own_req = |(r_grant & req);
    assign w_accept  = (r_state == BURST) && (|(r_grant & req & valid)) && !busy;
    assign w_last    = |(r_grant & last);
    assign w_cnt_nxt = r_cnt + CW'(1);
    assign w_ptr_nxt = (r_owner == IW'(N - 1)) ? '0 : r_owner + IW'(1);
    assign ack       = w_accept ? r_grant : '0;

    always_comb begin
        w_x     = '0;
        w_y     = '0;
        w_color = '0;
        for (int i = 0; i < N; i++) begin
            if (r_grant[i]) begin
                w_x     = x_in[i*X_W +: X_W];
                w_y     = y_in[i*Y_W +: Y_W];
                w_color = color_in[i*C_W +: C_W];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_owner <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_plot  <= 1'b0;
            r_x     <= '0;
            r_y     <= '0;
            r_color <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_plot <= 1'b0;
                    if (|req) begin
                        r_grant <= w_sel_onehot;
                        r_owner <= w_sel_index;
                        r_cnt   <= '0;
                        r_state <= BURST;
                    end
                end
                BURST: begin
                    if (w_accept) begin
                        r_plot  <= 1'b1;
                        r_x     <= w_x;
                        r_y     <= w_y;
                        r_color <= w_color;
                        r_cnt   <= w_cnt_nxt;
                        // Forced release at MAX_BURST keeps a stuck engine from starving others.
                        if (w_last || (w_cnt_nxt == CW'(MAX_BURST))) begin
                            r_state <= GAP;
                        end
                    end else begin
                        r_plot <= 1'b0;
                        if (!w_own_req) begin
                            r_state <= GAP;
                        end
                    end
                end
                GAP: begin
                    r_grant <= '0;
                    r_plot  <= 1'b0;
                    r_ptr   <= w_ptr_nxt;
                    r_state <= IDLE;
                end
                default: begin
                    r_grant <= '0;
                    r_plot  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign grant     = r_grant;
    assign plot      = r_plot;
    assign x_out     = r_x;
    assign y_out     = r_y;
    assign color_out = r_color;
    assign active    = (r_state != IDLE);
endmodule
`default_nettype wire
